// File: rtl/calc_pkg.sv
// Shared command codes, calc status encoding and sequencer state encoding.
package calc_pkg;

  localparam int unsigned CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_ADD  = 4'hA;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'hB;
  localparam logic [CMD_W-1:0] CMD_MUL  = 4'hC;
  localparam logic [CMD_W-1:0] CMD_EQ   = 4'hD;
  localparam logic [CMD_W-1:0] CMD_BKSP = 4'hE;
  localparam logic [CMD_W-1:0] CMD_CLR  = 4'hF;

  typedef enum logic [1:0] {
    STAT_READY = 2'd0,
    STAT_BUSY  = 2'd1,
    STAT_ERROR = 2'd2
  } calc_status_t;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE     = 3'd0;
  localparam seq_state_t S_ISSUE    = 3'd1;
  localparam seq_state_t S_SETTLE   = 3'd2;
  localparam seq_state_t S_WAIT     = 3'd3;
  localparam seq_state_t S_RECOVER  = 3'd4;
  localparam seq_state_t S_WAIT_CLR = 3'd5;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO; flush overrides push and pop.
module cmd_fifo
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [CMD_W-1:0]         din,
  output logic [CMD_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/calc_seq.sv
// Issues queued keypad commands to calc one at a time, with error/timeout recovery.
module calc_seq
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             in_cmd,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             calc_cmd,
  output logic                   calc_stb,
  input  logic [1:0]             calc_status,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   error,
  output logic                   timeout,
  input  logic                   err_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  seq_state_t       state;
  seq_state_t       state_nx;
  logic [CW-1:0]    cnt;
  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             flush;
  logic             load_cmd;
  logic             load_clr;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             set_err;
  logic             set_to;

  assign in_ready = !full && (state != S_RECOVER);
  assign busy     = (state != S_IDLE);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .flush (flush),
    .din   (in_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    flush    = 1'b0;
    load_cmd = 1'b0;
    load_clr = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    set_err  = 1'b0;
    set_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          load_cmd = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE:  state_nx = S_SETTLE;
      S_SETTLE: begin
        cnt_clr  = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (calc_status == STAT_READY) begin
          state_nx = S_IDLE;
        end else if (calc_status == STAT_ERROR) begin
          set_err  = 1'b1;
          load_clr = 1'b1;
          state_nx = S_RECOVER;
        end else if (cnt == CW'(TIMEOUT)) begin
          set_to   = 1'b1;
          load_clr = 1'b1;
          state_nx = S_RECOVER;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RECOVER: begin
        flush    = 1'b1;
        state_nx = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (calc_status == STAT_READY) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command/strobe registers are loaded on the way into ISSUE or RECOVER.
  always_ff @(posedge clock) begin
    if (reset) begin
      calc_cmd <= '0;
      calc_stb <= 1'b0;
      cnt      <= '0;
      error    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      calc_stb <= load_cmd || load_clr;
      if (load_cmd)      calc_cmd <= head;
      else if (load_clr) calc_cmd <= CMD_CLR;
      if (cnt_clr)       cnt <= '0;
      else if (cnt_inc)  cnt <= cnt + CW'(1);
      if (set_err)       error <= 1'b1;
      else if (err_ack)  error <= 1'b0;
      if (set_to)        timeout <= 1'b1;
      else if (err_ack)  timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with cycle-exact hand-computed expectations.
module tb_calc_seq;

  localparam logic [1:0] RDY = 2'd0;
  localparam logic [1:0] BSY = 2'd1;
  localparam logic [1:0] ERR = 2'd2;

  logic       clock;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] calc_cmd;
  logic       calc_stb;
  logic [1:0] calc_status;
  logic [3:0] level;
  logic       busy;
  logic       error;
  logic       timeout;
  logic       err_ack;

  int n_chk;
  int n_bad;

  calc_seq #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_cmd      (in_cmd),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .calc_cmd    (calc_cmd),
    .calc_stb    (calc_stb),
    .calc_status (calc_status),
    .level       (level),
    .busy        (busy),
    .error       (error),
    .timeout     (timeout),
    .err_ack     (err_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stb"},      calc_stb, 0);
    check({tag, "_cmd"},      calc_cmd, 0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_level"},    level,    0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_error"},    error,    0);
    check({tag, "_timeout"},  timeout,  0);
  endtask

  logic [3:0] cmds [4];
  int         nstb;
  int         acc;

  initial begin
    n_chk = 0;
    n_bad = 0;
    cmds  = '{4'h1, 4'hA, 4'h2, 4'hD};
    reset = 1'b1;
    in_valid = 1'b0;
    in_cmd = 4'h0;
    calc_status = RDY;
    err_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_vals("rst");
    step();
    check_reset_vals("rst_idle");

    // Normal sequence: 1, A, 2, D with READY throughout.
    nstb = 0;
    for (int k = 0; k < 18; k++) begin
      in_valid = (k < 4);
      in_cmd   = (k < 4) ? cmds[k] : 4'h0;
      if (k == 1) begin
        check("norm_level1", level, 1);
        check("norm_idle_busy", busy, 0);
      end
      if (k == 4) check("norm_level3", level, 3);
      if (k == 2 || k == 6 || k == 10 || k == 14) begin
        check("norm_stb", calc_stb, 1);
        check("norm_cmd", calc_cmd, cmds[(k - 2) / 4]);
      end
      nstb += int'(calc_stb);
      step();
    end
    check("norm_nstb", nstb, 4);
    check("norm_end_busy", busy, 0);

    // Busy hold: 16 BUSY cycles in WAIT, READY arrives as counter hits the limit.
    nstb = 0;
    for (int k = 0; k < 26; k++) begin
      in_valid    = (k == 0 || k == 3);
      in_cmd      = (k == 0) ? 4'h5 : 4'h6;
      calc_status = (k >= 20) ? RDY : BSY;
      if (k == 2) begin
        check("hold_stb5", calc_stb, 1);
        check("hold_cmd5", calc_cmd, 4'h5);
      end
      if (k >= 3 && k <= 21) nstb += int'(calc_stb);
      if (k == 20) check("hold_busy", busy, 1);
      if (k == 22) begin
        check("hold_stb6", calc_stb, 1);
        check("hold_cmd6", calc_cmd, 4'h6);
        check("hold_timeout", timeout, 0);
      end
      step();
    end
    check("hold_gap_nstb", nstb, 0);
    check("hold_end_busy", busy, 0);

    // Error on first of five queued commands.
    for (int k = 0; k < 11; k++) begin
      in_valid    = (k <= 5);
      in_cmd      = (k < 5) ? 4'(k + 1) : 4'h7;
      calc_status = (k <= 6) ? ERR : RDY;
      err_ack     = (k == 9);
      if (k == 2) begin
        check("err_stb1", calc_stb, 1);
        check("err_cmd1", calc_cmd, 4'h1);
      end
      if (k == 5) begin
        check("err_clr_stb", calc_stb, 1);
        check("err_clr_cmd", calc_cmd, 4'hF);
        check("err_flag", error, 1);
        check("err_recover_ready", in_ready, 0);
        check("err_level_pre", level, 4);
      end
      if (k == 6) begin
        check("err_level_flushed", level, 0);
        check("err_stb_once", calc_stb, 0);
      end
      if (k == 7) begin
        check("err_waitclr_busy", busy, 1);
        check("err_waitclr_stb", calc_stb, 0);
      end
      if (k == 8) begin
        check("err_idle", busy, 0);
        check("err_sticky", error, 1);
      end
      if (k == 9) check("err_empty_stb", calc_stb, 0);
      if (k == 10) check("err_ack_clr", error, 0);
      step();
    end

    // Fill FIFO while command is stuck BUSY, then let it time out.
    acc = 0;
    for (int k = 0; k < 25; k++) begin
      in_valid    = (k == 0) || (k >= 4 && k <= 12);
      in_cmd      = (k == 0) ? 4'h9 : 4'(k - 4);
      calc_status = (k >= 22) ? RDY : BSY;
      err_ack     = (k == 20 || k == 21);
      if (k == 12) begin
        check("full_level", level, 8);
        check("full_in_ready", in_ready, 0);
      end
      if (k >= 4 && k <= 12) acc += int'(in_valid && in_ready);
      if (k == 20) begin
        check("to_pre_stb", calc_stb, 0);
        check("to_pre_flag", timeout, 0);
      end
      if (k == 21) begin
        check("to_clr_stb", calc_stb, 1);
        check("to_clr_cmd", calc_cmd, 4'hF);
        check("to_flag_set_wins", timeout, 1);
        check("to_no_error", error, 0);
      end
      if (k == 22) begin
        check("to_ack_clr", timeout, 0);
        check("to_level_flushed", level, 0);
        check("to_waitclr_busy", busy, 1);
      end
      if (k == 23) check("to_idle", busy, 0);
      step();
    end
    check("full_accepted", acc, 8);

    // Reset while waiting on a BUSY command.
    nstb = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid    = (k <= 1);
      in_cmd      = (k == 0) ? 4'h3 : 4'h4;
      calc_status = (k >= 6) ? RDY : BSY;
      reset       = (k == 5);
      if (k == 5) begin
        check("rmid_busy", busy, 1);
        check("rmid_level", level, 1);
        check("rmid_cmd", calc_cmd, 4'h3);
      end
      if (k == 6) check_reset_vals("rmid");
      if (k >= 6) nstb += int'(calc_stb);
      step();
    end
    check("rmid_no_stb", nstb, 0);
    check("rmid_level_end", level, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
